// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (FSM state encoding, 16x oversample ratio, mid-bit sample index)
package uart_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer with parameterised reset value (clk, rst, d_i async in -> q_o synchronized out)
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end
    assign q_o = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (in: clk, rst, tick, rx; out: dout, rx_done, frame_err, parity_err); parity bit enabled by UART_RX_PARITY_EN
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int SB_TICKS   = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err
);
    localparam int SW = (SB_TICKS > OVERSAMPLE) ? 5 : 4;
    localparam int NW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] S_MID  = SW'(MID_SAMPLE);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);
    localparam logic PAR_SENSE = 1'(PARITY_ODD);
`ifdef UART_RX_PARITY_EN
    localparam uart_state_e ST_AFTER_DATA = ST_PARITY;
`else
    localparam uart_state_e ST_AFTER_DATA = ST_STOP;
`endif

    uart_state_e          state_q, state_d;
    logic                 rx_s;
    logic                 armed_q, armed_d;
    logic [SW-1:0]        s_cnt_q, s_cnt_d;
    logic [NW-1:0]        n_cnt_q, n_cnt_d;
    logic [DATA_BITS-1:0] b_q, b_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 mid_smp, bit_smp, stop_smp;
`ifdef UART_RX_PARITY_EN
    logic                 p_bad_q, p_bad_d;
    logic                 perr_q, perr_d;
`endif

    uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    assign mid_smp  = tick && (s_cnt_q == S_MID);
    assign bit_smp  = tick && (s_cnt_q == S_LAST);
    assign stop_smp = tick && (s_cnt_q == S_STOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            armed_q <= 1'b1;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            p_bad_q <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            p_bad_q <= p_bad_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = (armed_q && !rx_s) ? ST_START : ST_IDLE;
            ST_START:  state_d = mid_smp ? (rx_s ? ST_IDLE : ST_DATA) : ST_START;
            ST_DATA:   state_d = (bit_smp && n_cnt_q == N_LAST) ? ST_AFTER_DATA : ST_DATA;
`ifdef UART_RX_PARITY_EN
            ST_PARITY: state_d = bit_smp ? ST_STOP : ST_PARITY;
`endif
            ST_STOP:   state_d = stop_smp ? ST_IDLE : ST_STOP;
            default:   state_d = ST_IDLE;
        endcase
    end

    // A framing error disarms start detection until the line is seen idle,
    // so a held break produces a single frame instead of a stream.
    always_comb begin
        s_cnt_d = tick ? s_cnt_q + 1'b1 : s_cnt_q;
        n_cnt_d = n_cnt_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
        armed_d = armed_q | rx_s;
`ifdef UART_RX_PARITY_EN
        p_bad_d = p_bad_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            ST_IDLE: s_cnt_d = '0;
            ST_START: begin
                s_cnt_d = mid_smp ? '0 : s_cnt_d;
                n_cnt_d = mid_smp ? '0 : n_cnt_q;
            end
            ST_DATA: begin
                s_cnt_d = bit_smp ? '0 : s_cnt_d;
                b_d     = bit_smp ? {rx_s, b_q[DATA_BITS-1:1]} : b_q;
                n_cnt_d = (bit_smp && n_cnt_q != N_LAST) ? n_cnt_q + 1'b1 : n_cnt_q;
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                s_cnt_d = bit_smp ? '0 : s_cnt_d;
                p_bad_d = bit_smp ? (((^b_q) ^ rx_s) != PAR_SENSE) : p_bad_q;
            end
`endif
            ST_STOP: begin
                if (stop_smp) begin
                    s_cnt_d = '0;
                    dout_d  = b_q;
                    ferr_d  = ~rx_s;
                    done_d  = 1'b1;
                    armed_d = rx_s;
`ifdef UART_RX_PARITY_EN
                    perr_d  = p_bad_q;
`endif
                end
            end
            default: s_cnt_d = '0;
        endcase
    end

    assign dout      = dout_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = PAR_SENSE & 1'b0;
`endif
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive deserializer: samples an asynchronous serial line using the 16x-oversampled baud strobe from the team's baud-rate generator and recovers 8N1-style frames (LSB first). It is the receive end of the UART link. It sits between the board RX pin and the byte-level consumer, such as the interface FIFO or ALU front-end. Each completed frame is presented as a parallel word with a single-cycle done strobe and error flags.

## Interface
- DATA_BITS, 8, data bits per frame (5–8)
- SB_TICKS, 16, oversample ticks spent in stop bit (16 = 1 stop bit, 32 = 2)
- PARITY_ODD, 0, parity sense when parity is compiled in (0 = even, 1 = odd)

Ports:
- clk  in  1  system clock (50 MHz nominal)
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-clk-wide strobe at 16 × baud rate
- rx  in  1  raw serial input; idle high; asynchronous to clk
- dout  out  DATA_BITS  last received word
- rx_done  out  1  one-clk pulse: new word on dout
- frame_err  out  1  stop bit sampled low on the last frame
- parity_err  out  1  parity mismatch on the last frame (tied 0 without UART_RX_PARITY_EN)

## Operation
- **Input synchronizer:** rx passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value rx_s.
- **States:** IDLE, START, DATA, PARITY (present only with UART_RX_PARITY_EN), STOP.
- **Counters:**
  - s_cnt (4 bits, wraps naturally; 5 bits when SB_TICKS > 16): advances only on tick.
  - n_cnt: data-bit index, 0..DATA_BITS-1.
  - shift register b[DATA_BITS-1:0].
- **IDLE:**
  - When armed and rx_s == 0: go to START and clear s_cnt. This transition does not wait for tick.
  - A tick arriving in IDLE is ignored.
- **START:** on tick with s_cnt == 7 (mid start bit):
  - If rx_s == 0: go to DATA and clear s_cnt and n_cnt.
  - Otherwise: treat as a glitch and return to IDLE with no outputs changed.
  - On any other tick: s_cnt += 1.
- **DATA:** on tick with s_cnt == 15:
  - Clear s_cnt and shift b <= {rx_s, b[DATA_BITS-1:1]} (LSB first).
  - If n_cnt == DATA_BITS-1: go to PARITY if compiled in, else STOP.
  - Otherwise: n_cnt += 1.
- **PARITY:** on tick with s_cnt == 15:
  - Latch p_bad = (^b ^ rx_s) != PARITY_ODD.
  - Clear s_cnt and go to STOP.
- **STOP:** on tick with s_cnt == SB_TICKS-1:
  - dout <= b; frame_err <= ~rx_s; parity_err <= p_bad; rx_done <= 1; go to IDLE.
- **Arming (break hold-off):**
  - After a frame with frame_err, IDLE is disarmed until rx_s == 1 has been seen for at least one clk.
  - A held-low line (break) therefore yields exactly one rx_done, not a stream.
- **Output holding:** dout and the error flags are held until the next rx_done. Glitch aborts never touch them.

## Timing
- **Reset values:** state IDLE, armed, sync flops 1, dout 0, rx_done 0, frame_err 0, parity_err 0, all counters 0.
- **Reset mid-frame:** immediate return to the reset values. No rx_done is emitted.
- **Start detect:** 2 clk after the rx falling edge, because of the synchronizer.
- **Sampling points:**
  - Start bit is validated 8 ticks after START entry.
  - Each data bit is sampled 16 ticks later, at bit centre.
- **rx_done:** registered; high for exactly one clk, the cycle after the tick that samples the stop bit.
- **Frame latency:** from START entry to rx_done is 8 + 16·DATA_BITS (+16 with parity) + SB_TICKS ticks, + 1 clk.
- **Back-to-back frames:** a new start bit immediately following the stop-bit sample point must be accepted. IDLE reacts in the clk after rx_done.
- **Tick and rx edge in the same clk:** the synchronized edge is evaluated independently of tick. No tick is lost or double-counted.

## Configuration
- **UART_RX_PARITY_EN defined:**
  - PARITY state is present; one parity bit is expected between data and stop.
  - parity_err is computed per PARITY_ODD.
- **UART_RX_PARITY_EN undefined:**
  - No PARITY state; DATA goes directly to STOP.
  - parity_err is a constant 0.
  - PARITY_ODD is unused.

## Structure
- Shared package uart_pkg:
  - state encoding for IDLE, START, DATA, PARITY, STOP
  - OVERSAMPLE = 16
  - MID_SAMPLE = 7
  - These are shared with the future uart_tx.
- One sub-module: uart_rx_sync (2-flop synchronizer, reset value parameterised, here 1). The FSM and datapath stay in uart_rx.

## Test plan
- **Common bench setup:** 50 MHz clk; tick every 163 clk (19200 baud); ideal bit period 16 ticks.
- **Single frame:** 8N1 frame carrying 0xA5 -> one rx_done pulse, dout = 0xA5, frame_err = 0, parity_err = 0.
- **Start glitch:** rx low for 4 ticks, then high -> no rx_done, FSM back in IDLE, dout unchanged.
- **Back-to-back:** frames 0x00 then 0xFF with no idle gap -> two rx_done pulses, dout = 0x00 then 0xFF, no errors.
- **Framing error / break:** frame 0x3C with stop bit low, rx then held low for 20 bit times -> exactly one rx_done with dout = 0x3C, frame_err = 1. After rx returns high, a clean 0x5A frame gives dout = 0x5A, frame_err = 0.
- **Parity (UART_RX_PARITY_EN, PARITY_ODD = 0):**
  - 0x55 with parity bit 1 -> parity_err = 1.
  - 0x55 with parity bit 0 -> parity_err = 0.
- **Reset mid-frame:** rst pulsed during data bit 3 -> all outputs 0, no rx_done. The following 0x81 frame is received correctly.
